// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer commit controller.
// Allocates slots at issue, collects writeback results, retires the head entry onto the
// register-file commit port (at most one per cycle), raises a one-cycle rollback when a
// mispredicted branch retires, and answers operand-forwarding queries from the decoder.
module rob_commit_ctrl #(
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ROB_POS  = $clog2(ROB_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,

    input  logic               issue,
    input  logic [REG_W-1:0]   issue_rd,
    output logic [ROB_POS-1:0] issue_rob_pos,
    output logic               full,

    input  logic               wb_valid,
    input  logic [ROB_POS-1:0] wb_rob_pos,
    input  logic [DATA_W-1:0]  wb_val,
    input  logic               wb_mispred,
    input  logic [DATA_W-1:0]  wb_target,

    input  logic [ROB_POS-1:0] q1_pos,
    input  logic [ROB_POS-1:0] q2_pos,
    output logic               q1_ready,
    output logic               q2_ready,
    output logic [DATA_W-1:0]  q1_val,
    output logic [DATA_W-1:0]  q2_val,

    output logic               commit,
    output logic [REG_W-1:0]   commit_rd,
    output logic [DATA_W-1:0]  commit_val,
    output logic [ROB_POS-1:0] commit_rob_pos,

    output logic               rollback,
    output logic [DATA_W-1:0]  rollback_pc
);

    localparam int unsigned CNT_W = ROB_POS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_SIZE);

    // Pointers and occupancy
    logic [ROB_POS-1:0] head_q, head_d;
    logic [ROB_POS-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Entry storage
    logic              valid_q   [ROB_SIZE];
    logic              ready_q   [ROB_SIZE];
    logic [REG_W-1:0]  rd_q      [ROB_SIZE];
    logic [DATA_W-1:0] val_q     [ROB_SIZE];
    logic              mispred_q [ROB_SIZE];
    logic [DATA_W-1:0] target_q  [ROB_SIZE];

    // Registered commit / rollback port
    logic               commit_q;
    logic [REG_W-1:0]   commit_rd_q;
    logic [DATA_W-1:0]  commit_val_q;
    logic [ROB_POS-1:0] commit_pos_q;
    logic               rollback_q;
    logic [DATA_W-1:0]  rollback_pc_q;

    // A mispredicted entry has retired; the next enabled edge flushes the buffer.
    logic rb_pending_q, rb_pending_d;

    logic issue_fire;
    logic wb_fire;
    logic commit_fire;
    logic rollback_fire;
    logic flush;

    assign full          = (count_q == FULL_CNT);
    assign issue_rob_pos = tail_q;

    // Decide which operations take effect on the coming edge.
    always_comb begin
        flush         = rdy && rb_pending_q;
        issue_fire    = rdy && !rb_pending_q && issue && !full;
        wb_fire       = rdy && !rb_pending_q && wb_valid && valid_q[wb_rob_pos];
        commit_fire   = rdy && !rb_pending_q && (count_q != '0) && ready_q[head_q];
        rollback_fire = commit_fire && mispred_q[head_q];
    end

    // Next-state for head/tail/count and the pending-flush flag.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        rb_pending_d = rb_pending_q;
        if (flush) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            rb_pending_d = 1'b0;
        end else begin
            if (issue_fire) begin
                tail_d = tail_q + 1'b1;
            end
            if (commit_fire) begin
                head_d = head_q + 1'b1;
            end
            // Simultaneous issue and commit leave the count unchanged.
            count_d = count_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);
            if (rollback_fire) begin
                rb_pending_d = 1'b1;
            end
        end
    end

    // Pointer, occupancy and pending-flush registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rb_pending_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rb_pending_q <= rb_pending_d;
        end
    end

    // Entry array: writeback, then retire-clear, then allocation (later writes win).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                valid_q[i]   <= 1'b0;
                ready_q[i]   <= 1'b0;
                rd_q[i]      <= '0;
                val_q[i]     <= '0;
                mispred_q[i] <= 1'b0;
                target_q[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                valid_q[i] <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else begin
            if (wb_fire) begin
                ready_q[wb_rob_pos]   <= 1'b1;
                val_q[wb_rob_pos]     <= wb_val;
                mispred_q[wb_rob_pos] <= wb_mispred;
                target_q[wb_rob_pos]  <= wb_target;
            end
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
            if (issue_fire) begin
                valid_q[tail_q]   <= 1'b1;
                ready_q[tail_q]   <= 1'b0;
                rd_q[tail_q]      <= issue_rd;
                mispred_q[tail_q] <= 1'b0;
            end
        end
    end

    // Registered commit and rollback outputs; pulses drop on any edge without a retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_q      <= 1'b0;
            commit_rd_q   <= '0;
            commit_val_q  <= '0;
            commit_pos_q  <= '0;
            rollback_q    <= 1'b0;
            rollback_pc_q <= '0;
        end else begin
            commit_q   <= commit_fire;
            rollback_q <= rollback_fire;
            if (commit_fire) begin
                commit_rd_q  <= rd_q[head_q];
                commit_val_q <= val_q[head_q];
                commit_pos_q <= head_q;
            end
            if (rollback_fire) begin
                rollback_pc_q <= target_q[head_q];
            end
        end
    end

    assign commit         = commit_q;
    assign commit_rd      = commit_rd_q;
    assign commit_val     = commit_val_q;
    assign commit_rob_pos = commit_pos_q;
    assign rollback       = rollback_q;
    assign rollback_pc    = rollback_pc_q;

    // Forwarding queries; a same-cycle writeback bypasses the stored value.
    always_comb begin
        logic byp1;
        logic byp2;
        byp1     = wb_valid && (wb_rob_pos == q1_pos);
        byp2     = wb_valid && (wb_rob_pos == q2_pos);
        q1_ready = valid_q[q1_pos] && (byp1 || ready_q[q1_pos]);
        q2_ready = valid_q[q2_pos] && (byp2 || ready_q[q2_pos]);
        q1_val   = '0;
        q2_val   = '0;
        if (valid_q[q1_pos]) begin
            if (byp1) begin
                q1_val = wb_val;
            end else if (ready_q[q1_pos]) begin
                q1_val = val_q[q1_pos];
            end
        end
        if (valid_q[q2_pos]) begin
            if (byp2) begin
                q2_val = wb_val;
            end else if (ready_q[q2_pos]) begin
                q2_val = val_q[q2_pos];
            end
        end
    end

endmodule
